// File: rtl/tenet_requant_pack.sv
// Ternarizes signed MAC results against a threshold and packs VEC_LEN trits per output vector.
// Optional build macro TENET_REQUANT_STATS_EN adds the zero_cnt statistics output.
module tenet_requant_pack #(
   parameter int ACC_WIDTH  = 16,
   parameter int VEC_LEN    = 9,
   parameter int TRIT_WIDTH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            in_valid,
   input  logic signed [ACC_WIDTH-1:0]     in_acc,
   output logic                            in_ready,
   input  logic [ACC_WIDTH-2:0]            thr,
   input  logic                            flush,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [VEC_LEN*TRIT_WIDTH-1:0]   out_trits,
   output logic                            drop_err
`ifdef TENET_REQUANT_STATS_EN
   ,
   output logic [15:0]                     zero_cnt
`endif
);

   localparam int VW = VEC_LEN * TRIT_WIDTH;
   localparam logic [3:0] LAST_IDX = 4'(VEC_LEN - 1);
   localparam logic [TRIT_WIDTH-1:0] TRIT_POS = TRIT_WIDTH'(1);
   localparam logic [TRIT_WIDTH-1:0] TRIT_NEG = TRIT_WIDTH'(2);

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   state_t          state_q, state_d;
   logic [3:0]      idx_q, idx_d;
   logic [VW-1:0]   buf_q, buf_d;
   logic            out_valid_q, out_valid_d;
   logic [VW-1:0]   out_trits_q, out_trits_d;
   logic            drop_err_q, drop_err_d;

   logic signed [ACC_WIDTH:0] acc_ext, thr_pos, thr_neg;
   logic [TRIT_WIDTH-1:0]     trit;
   logic [VW-1:0]             buf_wr;
   logic                      accept, drain, out_free, vec_done;

   // One extra bit keeps -thr representable for the full unsigned threshold range.
   assign acc_ext = {in_acc[ACC_WIDTH-1], in_acc};
   assign thr_pos = {2'b00, thr};
   assign thr_neg = -thr_pos;

   always_comb begin
      trit = '0;
      if (acc_ext > thr_pos) begin
         trit = TRIT_POS;
      end else if (acc_ext < thr_neg) begin
         trit = TRIT_NEG;
      end
   end

   assign in_ready  = (state_q == COLLECT);
   assign accept    = in_valid && in_ready;
   assign drain     = out_valid_q && out_ready;
   assign out_free  = !out_valid_q || drain;
   assign vec_done  = (state_q == COLLECT) &&
                      ((accept && idx_q == LAST_IDX) || (flush && (idx_q != 4'd0 || accept)));

   always_comb begin
      buf_wr = buf_q;
      if (accept) begin
         for (int k = 0; k < VEC_LEN; k++) begin
            if (idx_q == 4'(k)) begin
               buf_wr[k*TRIT_WIDTH +: TRIT_WIDTH] = trit;
            end
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      buf_d       = buf_q;
      out_valid_d = out_valid_q;
      out_trits_d = out_trits_q;
      drop_err_d  = drop_err_q | (in_valid & ~in_ready);
      if (drain) begin
         out_valid_d = 1'b0;
      end
      case (state_q)
         COLLECT: begin
            buf_d = buf_wr;
            if (accept) begin
               idx_d = idx_q + 4'd1;
            end
            if (vec_done) begin
               if (out_free) begin
                  out_trits_d = buf_wr;
                  out_valid_d = 1'b1;
                  buf_d       = '0;
                  idx_d       = '0;
               end else begin
                  state_d = HOLD;
               end
            end
         end
         HOLD: begin
            if (out_free) begin
               out_trits_d = buf_q;
               out_valid_d = 1'b1;
               buf_d       = '0;
               idx_d       = '0;
               state_d     = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= COLLECT;
         idx_q       <= '0;
         buf_q       <= '0;
         out_valid_q <= 1'b0;
         out_trits_q <= '0;
         drop_err_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         buf_q       <= buf_d;
         out_valid_q <= out_valid_d;
         out_trits_q <= out_trits_d;
         drop_err_q  <= drop_err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_trits = out_trits_q;
   assign drop_err  = drop_err_q;

`ifdef TENET_REQUANT_STATS_EN
   logic [15:0] zero_cnt_q, zero_cnt_d, zeros;
   logic [16:0] zero_sum;

   always_comb begin
      zeros = '0;
      for (int k = 0; k < VEC_LEN; k++) begin
         if (out_trits_q[k*TRIT_WIDTH +: TRIT_WIDTH] == '0) begin
            zeros = zeros + 16'd1;
         end
      end
   end

   // Saturating accumulate of zero trits on every output handshake.
   assign zero_sum = {1'b0, zero_cnt_q} + {1'b0, zeros};

   always_comb begin
      zero_cnt_d = zero_cnt_q;
      if (drain) begin
         zero_cnt_d = zero_sum[16] ? 16'hFFFF : zero_sum[15:0];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         zero_cnt_q <= '0;
      end else begin
         zero_cnt_q <= zero_cnt_d;
      end
   end

   assign zero_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_tenet_requant_pack.sv
// Bench for tenet_requant_pack: queue-of-vectors model plus directed vectors with literal expectations.
module tb_tenet_requant_pack;
   localparam int AW = 16;
   localparam int VL = 9;
   localparam int TW = 2;
   localparam int OW = VL * TW;

   logic                 clk = 1'b0;
   logic                 rst = 1'b1;
   logic                 in_valid = 1'b0;
   logic signed [AW-1:0] in_acc = '0;
   logic                 in_ready;
   logic [AW-2:0]        thr = '0;
   logic                 flush = 1'b0;
   logic                 out_valid;
   logic                 out_ready = 1'b1;
   logic [OW-1:0]        out_trits;
   logic                 drop_err;
`ifdef TENET_REQUANT_STATS_EN
   logic [15:0]          zero_cnt;
`endif

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   tenet_requant_pack #(.ACC_WIDTH(AW), .VEC_LEN(VL), .TRIT_WIDTH(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_acc    (in_acc),
      .in_ready  (in_ready),
      .thr       (thr),
      .flush     (flush),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_trits (out_trits),
      .drop_err  (drop_err)
`ifdef TENET_REQUANT_STATS_EN
      ,
      .zero_cnt  (zero_cnt)
`endif
   );

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [1:0] tern(input logic signed [AW-1:0] a, input logic [AW-2:0] t);
      int ai;
      int ti;
      ai = a;
      ti = int'(t);
      if (ai > ti) return 2'b01;
      if (ai < -ti) return 2'b10;
      return 2'b00;
   endfunction

   function automatic int zeros_of(input logic [OW-1:0] v);
      int z = 0;
      for (int k = 0; k < VL; k++) begin
         if (v[k*TW +: TW] == 2'b00) z++;
      end
      return z;
   endfunction

   // Model: vectors completed but not yet consumed, at most one in the output slot plus one held.
   logic [OW-1:0] mq[$];
   logic [OW-1:0] cur_v = '0;
   int            cur_n = 0;
   logic          m_drop = 1'b0;
   int            m_zc = 0;

   always @(posedge clk) begin : model
      bit            rdy;
      logic [OW-1:0] popped;
      if (rst) begin
         mq.delete();
         cur_v  = '0;
         cur_n  = 0;
         m_drop = 1'b0;
         m_zc   = 0;
      end else begin
         rdy = (mq.size() < 2);
         if (in_valid && !rdy) m_drop = 1'b1;
         if (mq.size() > 0 && out_ready) begin
            popped = mq.pop_front();
            m_zc = m_zc + zeros_of(popped);
            if (m_zc > 65535) m_zc = 65535;
         end
         if (in_valid && rdy) begin
            cur_v[cur_n*TW +: TW] = tern(in_acc, thr);
            cur_n++;
         end
         if (rdy && (cur_n == VL || (flush && cur_n > 0))) begin
            mq.push_back(cur_v);
            cur_v = '0;
            cur_n = 0;
         end
      end
   end

   always @(negedge clk) begin : compare
      check("out_valid", int'(out_valid), int'(mq.size() > 0));
      check("in_ready", int'(in_ready), int'(mq.size() < 2));
      check("drop_err", int'(drop_err), int'(m_drop));
      if (mq.size() > 0) check("out_trits", int'(out_trits), int'(mq[0]));
`ifdef TENET_REQUANT_STATS_EN
      check("zero_cnt", int'(zero_cnt), m_zc);
`endif
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic acc1(input int v);
      in_valid = 1'b1;
      in_acc   = AW'(v);
      step();
      in_valid = 1'b0;
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "timeout");
   end

   int t1_acc[VL] = '{11, 10, -11, -10, 0, 300, -300, 11, -1};

   initial begin : stim
      step();
      step();
      rst = 1'b0;
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_in_ready", int'(in_ready), 1);
      check("rst_drop_err", int'(drop_err), 0);
      check("rst_out_trits", int'(out_trits), 0);

      // Mixed signs against thr=10, consumer always ready
      thr = 15'd10;
      foreach (t1_acc[i]) acc1(t1_acc[i]);
      check("t1_valid", int'(out_valid), 1);
      check("t1_trits", int'(out_trits), 'h06421);
      step();
      check("t1_drained", int'(out_valid), 0);

      // Back-pressure: second vector is held until the first drains
      out_ready = 1'b0;
      thr = 15'd0;
      for (int i = 0; i < 2*VL; i++) begin
         acc1(50);
         if (i == VL-1) check("t2_first", int'(out_trits), 'h15555);
      end
      check("t2_hold_rdy", int'(in_ready), 0);
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check("t2_second_valid", int'(out_valid), 1);
      check("t2_second_rdy", int'(in_ready), 1);
      check("t2_second_trits", int'(out_trits), 'h15555);
      out_ready = 1'b1;
      step();
      check("t2_drained", int'(out_valid), 0);

      // Sample in HOLD is dropped; flush with empty buffer does nothing
      out_ready = 1'b0;
      for (int i = 0; i < 2*VL; i++) acc1(-50);
      in_valid = 1'b1;
      in_acc   = 16'sd77;
      step();
      in_valid = 1'b0;
      check("t3_drop", int'(drop_err), 1);
      out_ready = 1'b1;
      step();
      step();
      check("t3_empty", int'(out_valid), 0);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t3_flush0", int'(out_valid), 0);
      step();
      check("t3_flush0_late", int'(out_valid), 0);
      check("t3_drop_sticky", int'(drop_err), 1);

      // Drain and new transfer in the same cycle
      out_ready = 1'b0;
      for (int i = 0; i < VL; i++) acc1(50);
      for (int i = 0; i < VL-1; i++) acc1(-50);
      in_valid  = 1'b1;
      in_acc    = -16'sd50;
      out_ready = 1'b1;
      step();
      in_valid  = 1'b0;
      out_ready = 1'b0;
      check("t8_valid", int'(out_valid), 1);
      check("t8_trits", int'(out_trits), 'h2AAAA);
      out_ready = 1'b1;
      step();
      check("t8_drained", int'(out_valid), 0);

      // Reset clears drop_err; partial vector via flush
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t4_drop_clr", int'(drop_err), 0);
      acc1(5);
      acc1(-5);
      acc1(5);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t4_valid", int'(out_valid), 1);
      check("t4_trits", int'(out_trits), 'h00019);
      step();
`ifdef TENET_REQUANT_STATS_EN
      check("t4_zero_cnt", int'(zero_cnt), 6);
`endif

      // Flush together with an accept includes that sample
      in_valid = 1'b1;
      in_acc   = 16'sd7;
      flush    = 1'b1;
      step();
      in_valid = 1'b0;
      flush    = 1'b0;
      check("t5_trits", int'(out_trits), 'h00001);
      step();

      // Reset mid-vector and with a held vector
      for (int i = 0; i < 5; i++) acc1(-50);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("t6_rst_valid", int'(out_valid), 0);
      for (int i = 0; i < VL; i++) acc1(50);
      check("t6_post_trits", int'(out_trits), 'h15555);
      step();
      check("t6_single", int'(out_valid), 0);
      out_ready = 1'b0;
      for (int i = 0; i < 2*VL; i++) acc1(-50);
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      check("t6_hold_rst_valid", int'(out_valid), 0);
      check("t6_hold_rst_rdy", int'(in_ready), 1);

      // Threshold extremes
      thr = 15'd32767;
      acc1(-32768);
      acc1(32767);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("t7_trits", int'(out_trits), 'h00002);
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
